// File: rtl/keypad_scan_pkg.sv
// Shared types, key codes and decode helpers for the 4x3 keypad scanner.
// Key code = row*3 + col; '*', '0' and '#' sit on row 3.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONFIRM,
    ST_HELD
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_SINGLE,
    RES_MULTI
  } sweep_kind_t;

  typedef logic [3:0] key_code_t;

  localparam key_code_t KEY_STAR = 4'd9;
  localparam key_code_t KEY_ZERO = 4'd10;
  localparam key_code_t KEY_HASH = 4'd11;

  // Digits 1..9 land on num[9..1]; '0' lands on num[0].
  function automatic logic [9:0] code_to_num(input key_code_t code);
    logic [9:0] num;
    num = '0;
    if (code <= 4'd8)
      num[4'd9 - code] = 1'b1;
    else if (code == KEY_ZERO)
      num[0] = 1'b1;
    return num;
  endfunction

  function automatic logic [1:0] code_to_ctrl(input key_code_t code);
    logic [1:0] ctrl;
    ctrl = 2'b00;
    if (code == KEY_STAR)
      ctrl = 2'b10;
    else if (code == KEY_HASH)
      ctrl = 2'b01;
    return ctrl;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad pins plus the level outputs consumed by the LCD entry controller.
// The scanner uses the master view; the keypad/consumer side uses slave.
interface keypad_scan_if;
  logic [3:0] row;
  logic [2:0] col;
  logic [9:0] num;
  logic [1:0] ctrl;
  logic       key_valid;

  modport master (input row, output col, num, ctrl, key_valid);
  modport slave  (output row, input col, num, ctrl, key_valid);
endinterface

// File: rtl/keypad_scan_debounce.sv
// Sweep-level debouncer: a key must be seen alone for DEBOUNCE sweeps to be
// accepted, and DEBOUNCE empty sweeps are needed to release it.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sweep_done,
  input  sweep_kind_t kind,
  input  key_code_t   code,
  output key_code_t   held_code,
  output logic        held_valid
);

  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

  state_t           state, state_next;
  logic [DB_W-1:0]  dbcnt, dbcnt_next, dbcnt_inc;
  key_code_t        cand, cand_next;
  key_code_t        held_q, held_next;

  assign dbcnt_inc = (dbcnt == DB_MAX) ? dbcnt : dbcnt + DB_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= ST_IDLE;
      dbcnt  <= '0;
      cand   <= '0;
      held_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state  <= state_next;
      dbcnt  <= dbcnt_next;
      cand   <= cand_next;
      held_q <= held_next;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    state_next = state;
    dbcnt_next = dbcnt;
    cand_next  = cand;
    held_next  = held_q;
    if (sweep_done) begin
      unique case (state)
        ST_IDLE: if (kind == RES_SINGLE) begin
          cand_next = code;
          if (DEBOUNCE == 1) begin
            state_next = ST_HELD;
            held_next  = code;
            dbcnt_next = '0;
          end else begin
            state_next = ST_CONFIRM;
            dbcnt_next = DB_W'(1);
          end
        end
        ST_CONFIRM: begin
          if (kind == RES_SINGLE && code == cand) begin
            if (dbcnt == DB_LAST) begin
              state_next = ST_HELD;
              held_next  = cand;
              dbcnt_next = '0;
            end else begin
              dbcnt_next = dbcnt_inc;
            end
          end else if (kind == RES_SINGLE) begin
            cand_next  = code;
            dbcnt_next = DB_W'(1);
          end else begin
            state_next = ST_IDLE;
            dbcnt_next = '0;
          end
        end
        ST_HELD: begin
          if (kind == RES_NONE) begin
            if (dbcnt == DB_LAST) begin
              state_next = ST_IDLE;
              dbcnt_next = '0;
            end else begin
              dbcnt_next = dbcnt_inc;
            end
          end else begin
            dbcnt_next = '0;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    held_valid = (state == ST_HELD);
    held_code  = held_q;
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x3 keypad front end: column scanner, row synchronizer, sweep accumulator
// and registered one-hot decode of the debounced key.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  keypad_scan_if.master bus
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [3:0]       row_s1, row_s2;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col_idx;
  logic [2:0]       col_q;
  logic [1:0]       acc_cnt;
  key_code_t        acc_code;
  logic             sample, sweep_done;
  logic [2:0]       col_hits;
  key_code_t        col_code;
  logic [3:0]       total;
  logic [1:0]       sweep_cnt;
  key_code_t        sweep_code;
  sweep_kind_t      sweep_kind;
  key_code_t        held_code;
  logic             held_valid;
  logic [9:0]       num_q;
  logic [1:0]       ctrl_q;
  logic             valid_q;

  assign sample     = (div_cnt == DIV_LAST);
  assign sweep_done = sample && (col_idx == 2'd2);

  // Fold the current column's sample into the running sweep tally; the count
  // saturates at 2 because anything beyond "more than one" is just MULTI.
  always_comb begin
    col_hits = '0;
    col_code = '0;
    for (int r = 0; r < 4; r++) begin
      if (row_s2[r]) begin
        col_hits = col_hits + 3'd1;
        col_code = key_code_t'(r * 3) + key_code_t'(col_idx);
      end
    end
    total      = 4'(acc_cnt) + 4'(col_hits);
    sweep_cnt  = (total >= 4'd2) ? 2'd2 : total[1:0];
    sweep_code = (col_hits == 3'd1) ? col_code : acc_code;
    case (sweep_cnt)
      2'd0:    sweep_kind = RES_NONE;
      2'd1:    sweep_kind = RES_SINGLE;
      default: sweep_kind = RES_MULTI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      row_s1   <= '0;
      row_s2   <= '0;
      div_cnt  <= '0;
      col_idx  <= '0;
      col_q    <= 3'b001;
      acc_cnt  <= '0;
      acc_code <= '0;
      num_q    <= '0;
      ctrl_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      row_s1  <= bus.row;
      row_s2  <= row_s1;
      div_cnt <= sample ? '0 : div_cnt + DIV_W'(1);
      if (sample) begin
        col_idx <= (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
        col_q   <= {col_q[1:0], col_q[2]};
        if (sweep_done) begin
          acc_cnt  <= '0;
          acc_code <= '0;
        end else begin
          acc_cnt  <= sweep_cnt;
          acc_code <= sweep_code;
        end
      end
      num_q   <= held_valid ? code_to_num(held_code)  : '0;
      ctrl_q  <= held_valid ? code_to_ctrl(held_code) : '0;
      valid_q <= held_valid;
    end
  end

  keypad_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .sweep_done (sweep_done),
    .kind       (sweep_kind),
    .code       (sweep_code),
    .held_code  (held_code),
    .held_valid (held_valid)
  );

  assign bus.col       = col_q;
  assign bus.num       = num_q;
  assign bus.ctrl      = ctrl_q;
  assign bus.key_valid = valid_q;

endmodule
